// File: rtl/flowreg_pkg.sv
// flowreg_pkg: definitions shared by the flowreg_* blocks.
//   cnt_w(depth) : width of an occupancy counter that holds 0..depth
//   hs_t         : handshake bundle {data, valid}. The data field is sized for the
//                  widest supported word; narrower users zero-extend into it.
package flowreg_pkg;

  localparam int HS_MAX_W = 64;

  typedef struct packed {
    logic [HS_MAX_W-1:0] data;
    logic                valid;
  } hs_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/flowreg_fifo_if.sv
// flowreg_fifo_if: handshake bundle around an elastic buffer.
//   upstream   : d_u, v_u (to buffer), r_u (from buffer)
//   downstream : d_d, v_d (from buffer), r_d (to buffer)
//   control    : flush (to buffer), count (occupancy, from buffer)
// master = producer/consumer environment, slave = the buffer.
interface flowreg_fifo_if
  import flowreg_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
);
  localparam int CW = cnt_w(DEPTH);

  logic [W-1:0]  d_u;
  logic          v_u;
  logic          r_u;
  logic [W-1:0]  d_d;
  logic          v_d;
  logic          r_d;
  logic          flush;
  logic [CW-1:0] count;

  modport master (
    output d_u, v_u, r_d, flush,
    input  r_u, d_d, v_d, count
  );

  modport slave (
    input  d_u, v_u, r_d, flush,
    output r_u, d_d, v_d, count
  );

endinterface

// File: rtl/flowreg_store.sv
// flowreg_store: DEPTH x W register array for the elastic buffer.
//   clk_i     : clock
//   we_i      : write enable
//   waddr_i   : write address
//   wdata_i   : write data
//   raddr_i   : read address (asynchronous read)
//   rdata_o   : read data
// The array has no reset; validity is tracked by the owner's pointers/count.
module flowreg_store #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [DEPTH-1:0][W-1:0] mem_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/flowreg_fifo.sv
// flowreg_fifo: DEPTH-entry elastic buffer with valid/ready on both sides,
// occupancy output and synchronous flush. One transfer per cycle per side,
// one cycle of latency (no empty bypass).
//   clk : clock
//   rst : synchronous active-high reset
//   bus : flowreg_fifo_if.slave (d_u/v_u/r_u, d_d/v_d/r_d, flush, count)
// Both r_u and v_d come from registered state plus rst/flush, so there is no
// combinational path r_d -> r_u or v_u -> v_d.
module flowreg_fifo
  import flowreg_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  flowreg_fifo_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("flowreg_fifo: DEPTH must be a power of two >= 2");
  end
  if (W < 1 || W > HS_MAX_W) begin : g_bad_width
    $error("flowreg_fifo: W out of range for hs_t");
  end

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, empty, r_u, v_d, push, pop;
  logic [W-1:0]  rdata;
  hs_t           up_s;
  logic          unused_hs;

  assign up_s      = '{data: HS_MAX_W'(bus.d_u), valid: bus.v_u};
  // Bits above W are zero padding of the shared bundle.
  assign unused_hs = ^up_s.data;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Full blocks a push even if a pop happens on the same edge; r_u recovers
  // the cycle after the pop.
  assign r_u  = !rst && !bus.flush && !full;
  assign v_d  = !empty;
  assign push = up_s.valid && r_u;
  assign pop  = v_d && bus.r_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      // Any pop on a flush edge is discarded along with the contents.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  flowreg_store #(.W(W), .DEPTH(DEPTH), .AW(AW)) u_store (
    .clk_i   (clk),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (up_s.data[W-1:0]),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  assign bus.r_u   = r_u;
  assign bus.v_d   = v_d;
  assign bus.d_d   = rdata;
  assign bus.count = count_q;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(pop && empty));

endmodule

// File: tb/tb_flowreg_fifo.sv
module tb_flowreg_fifo;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  flowreg_fifo_if #(.W(8),  .DEPTH(4)) a_if ();
  flowreg_fifo_if #(.W(16), .DEPTH(8)) b_if ();

  flowreg_fifo #(.W(8), .DEPTH(4)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a_if.slave)
  );

  flowreg_fifo #(.W(16), .DEPTH(8)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  // Advance to just after the next rising edge; inputs are then driven for the
  // following edge and outputs checked 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_if.v_u = 1'b1; a_if.d_u = 8'h99; a_if.r_d = 1'b0; a_if.flush = 1'b0;
    b_if.v_u = 1'b0; b_if.d_u = '0;    b_if.r_d = 1'b0; b_if.flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (a_if.r_u !== 1'b0) begin bad++; $display("FAIL reset_r_u cyc=%0d got=%b exp=0", i, a_if.r_u); end
      total++;
      if (a_if.v_d !== 1'b0) begin bad++; $display("FAIL reset_v_d cyc=%0d got=%b exp=0", i, a_if.v_d); end
      total++;
      if (a_if.count !== 3'd0) begin bad++; $display("FAIL reset_count cyc=%0d got=%0d exp=0", i, a_if.count); end
      total++;
    end
    rst = 1'b0;
    a_if.v_u = 1'b0;
    #1;
    if (a_if.r_u !== 1'b1) begin bad++; $display("FAIL reset_release_r_u got=%b exp=1", a_if.r_u); end
    total++;
    if (a_if.v_d !== 1'b0) begin bad++; $display("FAIL reset_release_v_d got=%b exp=0", a_if.v_d); end
    total++;
    tick();
    if (a_if.count !== 3'd0 || a_if.v_d !== 1'b0) begin
      bad++; $display("FAIL reset_nothing_stored count=%0d v_d=%b exp=0/0", a_if.count, a_if.v_d);
    end
    total++;
  endtask

  task automatic test_single();
    // r_d=1 while empty: the word must not be popped on the same edge.
    a_if.v_u = 1'b1; a_if.d_u = 8'h11; a_if.r_d = 1'b1;
    tick();
    a_if.v_u = 1'b0; a_if.r_d = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (a_if.v_d !== 1'b1 || a_if.d_d !== 8'h11) begin
        bad++; $display("FAIL single_hold cyc=%0d v_d=%b d_d=%h exp=1/11", i, a_if.v_d, a_if.d_d);
      end
      total++;
      if (a_if.count !== 3'd1) begin bad++; $display("FAIL single_count cyc=%0d got=%0d exp=1", i, a_if.count); end
      total++;
      tick();
    end
    a_if.r_d = 1'b1;
    tick();
    a_if.r_d = 1'b0;
    #1;
    if (a_if.v_d !== 1'b0 || a_if.count !== 3'd0) begin
      bad++; $display("FAIL single_pop v_d=%b count=%0d exp=0/0", a_if.v_d, a_if.count);
    end
    total++;
  endtask

  task automatic test_fill();
    logic [7:0] wv[4];
    logic [7:0] ev[4];
    wv = '{8'h11, 8'h22, 8'h33, 8'h44};
    ev = '{8'h22, 8'h33, 8'h44, 8'h55};
    a_if.r_d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_if.v_u = 1'b1; a_if.d_u = wv[i];
      tick();
    end
    a_if.d_u = 8'h55;
    for (int i = 0; i < 2; i++) begin
      #1;
      if (a_if.count !== 3'd4 || a_if.r_u !== 1'b0) begin
        bad++; $display("FAIL fill_full cyc=%0d count=%0d r_u=%b exp=4/0", i, a_if.count, a_if.r_u);
      end
      total++;
      tick();
    end
    // Pop while full with v_u held: push must not happen on this edge.
    a_if.r_d = 1'b1;
    #1;
    if (a_if.d_d !== 8'h11) begin bad++; $display("FAIL fill_head got=%h exp=11", a_if.d_d); end
    total++;
    tick();
    a_if.r_d = 1'b0;
    #1;
    if (a_if.count !== 3'd3 || a_if.r_u !== 1'b1) begin
      bad++; $display("FAIL fill_after_pop count=%0d r_u=%b exp=3/1", a_if.count, a_if.r_u);
    end
    total++;
    tick();
    a_if.v_u = 1'b0;
    #1;
    if (a_if.count !== 3'd4) begin bad++; $display("FAIL fill_refill count=%0d exp=4", a_if.count); end
    total++;
    for (int i = 0; i < 4; i++) begin
      a_if.r_d = 1'b1;
      #1;
      if (a_if.v_d !== 1'b1 || a_if.d_d !== ev[i]) begin
        bad++; $display("FAIL fill_order idx=%0d v_d=%b d_d=%h exp=1/%h", i, a_if.v_d, a_if.d_d, ev[i]);
      end
      total++;
      tick();
    end
    a_if.r_d = 1'b0;
    #1;
    if (a_if.count !== 3'd0 || a_if.v_d !== 1'b0) begin
      bad++; $display("FAIL fill_drained count=%0d v_d=%b exp=0/0", a_if.count, a_if.v_d);
    end
    total++;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 20; i++) begin
      a_if.v_u = 1'b1; a_if.r_d = 1'b1; a_if.d_u = 8'(i);
      #1;
      if (i > 0) begin
        if (a_if.v_d !== 1'b1 || a_if.d_d !== 8'(i - 1)) begin
          bad++; $display("FAIL stream_data cyc=%0d v_d=%b d_d=%h exp=1/%h", i, a_if.v_d, a_if.d_d, 8'(i - 1));
        end
        total++;
        if (a_if.count !== 3'd1) begin bad++; $display("FAIL stream_count cyc=%0d got=%0d exp=1", i, a_if.count); end
        total++;
      end
      tick();
    end
    a_if.v_u = 1'b0;
    #1;
    if (a_if.d_d !== 8'h13 || a_if.count !== 3'd1) begin
      bad++; $display("FAIL stream_last d_d=%h count=%0d exp=13/1", a_if.d_d, a_if.count);
    end
    total++;
    tick();
    a_if.r_d = 1'b0;
    #1;
    if (a_if.count !== 3'd0) begin bad++; $display("FAIL stream_end count=%0d exp=0", a_if.count); end
    total++;
  endtask

  task automatic test_flush();
    a_if.r_d = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      a_if.v_u = 1'b1; a_if.d_u = 8'(i);
      tick();
    end
    a_if.flush = 1'b1; a_if.v_u = 1'b1; a_if.d_u = 8'h77; a_if.r_d = 1'b1;
    #1;
    if (a_if.count !== 3'd3) begin bad++; $display("FAIL flush_pre_count got=%0d exp=3", a_if.count); end
    total++;
    if (a_if.r_u !== 1'b0) begin bad++; $display("FAIL flush_r_u got=%b exp=0", a_if.r_u); end
    total++;
    tick();
    a_if.flush = 1'b0; a_if.v_u = 1'b0; a_if.r_d = 1'b0;
    #1;
    if (a_if.count !== 3'd0 || a_if.v_d !== 1'b0) begin
      bad++; $display("FAIL flush_cleared count=%0d v_d=%b exp=0/0", a_if.count, a_if.v_d);
    end
    total++;
    a_if.v_u = 1'b1; a_if.d_u = 8'hA5;
    tick();
    a_if.v_u = 1'b0;
    #1;
    if (a_if.count !== 3'd1 || a_if.v_d !== 1'b1 || a_if.d_d !== 8'hA5) begin
      bad++; $display("FAIL flush_next count=%0d v_d=%b d_d=%h exp=1/1/a5", a_if.count, a_if.v_d, a_if.d_d);
    end
    total++;
    a_if.r_d = 1'b1;
    tick();
    a_if.r_d = 1'b0;
    #1;
    if (a_if.count !== 3'd0 || a_if.v_d !== 1'b0) begin
      bad++; $display("FAIL flush_alone count=%0d v_d=%b exp=0/0", a_if.count, a_if.v_d);
    end
    total++;
  endtask

  task automatic test_random();
    logic [15:0] q[$];
    int          cm;
    logic        vu, rd;
    logic [15:0] dv;
    b_if.flush = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      vu = ($urandom_range(0, 1) == 1);
      // Alternate drain-heavy and fill-heavy phases so full and empty both occur.
      rd = ($urandom_range(0, 3) < ((((c / 500) % 2) == 1) ? 3 : 1));
      dv = 16'($urandom);
      b_if.v_u = vu; b_if.d_u = dv; b_if.r_d = rd;
      #1;
      cm = q.size();
      if (b_if.count !== 4'(cm)) begin bad++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", c, b_if.count, cm); end
      total++;
      if (b_if.r_u !== (cm != 8)) begin bad++; $display("FAIL rand_r_u cyc=%0d got=%b exp=%b", c, b_if.r_u, cm != 8); end
      total++;
      if (b_if.v_d !== (cm != 0)) begin bad++; $display("FAIL rand_v_d cyc=%0d got=%b exp=%b", c, b_if.v_d, cm != 0); end
      total++;
      if (cm != 0) begin
        if (b_if.d_d !== q[0]) begin bad++; $display("FAIL rand_data cyc=%0d got=%h exp=%h", c, b_if.d_d, q[0]); end
        total++;
      end
      if (rd && cm != 0) void'(q.pop_front());
      if (vu && cm != 8) q.push_back(dv);
      tick();
    end
    b_if.v_u = 1'b0; b_if.r_d = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_flush();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
